cpu_controller: RTL and testbench

//  Instruction sequencer that drives the CPU datapath. Fetches 23-bit words from a synchronous ROM,

---
 rtl/cpu_controller.sv | 170 +++++++++++++++++
 tb/tb_cpu_controller.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// cpu_controller: instruction sequencer for the CPU datapath.
// Fetches 23-bit words from a synchronous ROM, decodes mv/mvi/alu/nop/halt
// and drives one-hot register enables, one-hot bus selects and the code word.
// Optional single-step mode: define CPU_CTRL_STEP_EN to add the step input.
module cpu_controller #(
    parameter int              PC_W       = 6,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef CPU_CTRL_STEP_EN
    input  logic            step,
`endif
    input  logic [22:0]     instr,
    output logic [PC_W-1:0] address,
    output logic [19:0]     r_en_OH,
    output logic [19:0]     tri_controller_OH,
    output logic [22:0]     code,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        FETCH_IMM,
        LOAD_IMM,
        T1,
        T2,
        T3,
        HALT
    } state_t;

    localparam logic [2:0]      OPC_MV   = 3'b000;
    localparam logic [2:0]      OPC_MVI  = 3'b001;
    localparam logic [2:0]      OPC_ALU  = 3'b010;
    localparam logic [2:0]      OPC_HALT = 3'b111;
    localparam int              SEL_G    = 8;
    localparam int              SEL_A    = 9;
    localparam int              SEL_IMM  = 9;
    localparam logic [PC_W-1:0] PC_INC   = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          next_state;
    state_t          done_state;
    logic [PC_W-1:0] pc;
    logic [2:0]      ir_aluop;
    logic [2:0]      ir_opc;
    logic [2:0]      ir_rx;
    logic [2:0]      ir_ry;
    logic [15:0]     imm_reg;
    logic            imm_wait_done;
    logic            start_instr;
    logic            continue_run;

    // In step mode a step pulse starts one instruction and every instruction
    // returns to IDLE; otherwise the run level both starts and continues.
`ifdef CPU_CTRL_STEP_EN
    assign start_instr  = step;
    assign continue_run = 1'b0;
`else
    assign start_instr  = run;
    assign continue_run = run;
`endif

    assign address = pc;
    assign busy    = (state != IDLE) && (state != HALT);
    assign halted  = (state == HALT);

    // State, program counter, instruction fields and the latched immediate.
    // The immediate word needs two wait cycles: the ROM still shows the opcode
    // word during the first cycle after the PC moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= START_ADDR;
            ir_aluop      <= '0;
            ir_opc        <= '0;
            ir_rx         <= '0;
            ir_ry         <= '0;
            imm_reg       <= '0;
            imm_wait_done <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                DECODE: begin
                    ir_aluop <= instr[22:20];
                    ir_opc   <= instr[19:17];
                    ir_rx    <= instr[16:14];
                    ir_ry    <= instr[13:11];
                    pc       <= pc + PC_INC;
                end
                FETCH_IMM: begin
                    imm_wait_done <= ~imm_wait_done;
                    if (imm_wait_done) begin
                        imm_reg <= instr[15:0];
                    end
                end
                LOAD_IMM: begin
                    pc <= pc + PC_INC;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic; opcode dispatch looks at the ROM word during DECODE.
    always_comb begin
        next_state = state;
        done_state = continue_run ? FETCH : IDLE;
        case (state)
            IDLE:      next_state = start_instr ? FETCH : IDLE;
            FETCH:     next_state = DECODE;
            DECODE: begin
                case (instr[19:17])
                    OPC_MV:   next_state = T1;
                    OPC_MVI:  next_state = FETCH_IMM;
                    OPC_ALU:  next_state = T1;
                    OPC_HALT: next_state = HALT;
                    default:  next_state = done_state;
                endcase
            end
            FETCH_IMM: next_state = imm_wait_done ? LOAD_IMM : FETCH_IMM;
            LOAD_IMM:  next_state = done_state;
            T1:        next_state = (ir_opc == OPC_MV) ? done_state : T2;
            T2:        next_state = T3;
            T3:        next_state = done_state;
            HALT:      next_state = HALT;
            default:   next_state = IDLE;
        endcase
    end

    // Datapath controls, decoded from the current state and IR fields only.
    always_comb begin
        r_en_OH           = '0;
        tri_controller_OH = '0;
        code              = '0;
        case (state)
            T1: begin
                if (ir_opc == OPC_MV) begin
                    tri_controller_OH[{2'b00, ir_ry}] = 1'b1;
                    r_en_OH[{2'b00, ir_rx}]           = 1'b1;
                end else begin
                    tri_controller_OH[{2'b00, ir_rx}] = 1'b1;
                    r_en_OH[SEL_A]                    = 1'b1;
                end
            end
            T2: begin
                tri_controller_OH[{2'b00, ir_ry}] = 1'b1;
                code[22:20]                       = ir_aluop;
                r_en_OH[SEL_G]                    = 1'b1;
            end
            T3: begin
                tri_controller_OH[SEL_G] = 1'b1;
                r_en_OH[{2'b00, ir_rx}]  = 1'b1;
            end
            LOAD_IMM: begin
                code[15:0]                 = imm_reg;
                tri_controller_OH[SEL_IMM] = 1'b1;
                r_en_OH[{2'b00, ir_rx}]    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: self-checking bench for cpu_controller.
// Table-driven single-instruction vectors, hand sequences for reset, wrap and
// run handling, and random programs checked against an instruction-level model.
// Define CPU_CTRL_STEP_EN to exercise the single-step build instead.
module tb_cpu_controller;

    localparam logic [22:0] HALT_W = 23'h0E0000;
    localparam logic [22:0] NOP_W  = 23'h060000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
`ifdef CPU_CTRL_STEP_EN
    logic        step;
`endif
    logic [22:0] instr = '0;
    logic [5:0]  address;
    logic [19:0] r_en_OH;
    logic [19:0] tri_controller_OH;
    logic [22:0] code;
    logic        busy;
    logic        halted;

    logic [22:0] rom [64];

    int assertions = 0;
    int failures   = 0;
    bit last_ok;

    typedef struct packed {
        logic [5:0]  addr;
        logic [19:0] ren;
        logic [19:0] tsel;
        logic [22:0] code;
        logic        busy;
        logic        halted;
    } obs_t;

    typedef struct packed {
        logic [22:0]       w0;
        logic [22:0]       w1;
        logic [7:0]        cycles;
        logic [7:0]        n_act;
        logic [2:0][19:0]  ren;
        logic [2:0][19:0]  tsel;
        logic [2:0][22:0]  code;
    } vec_t;

    cpu_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .run               (run),
`ifdef CPU_CTRL_STEP_EN
        .step              (step),
`endif
        .instr             (instr),
        .address           (address),
        .r_en_OH           (r_en_OH),
        .tri_controller_OH (tri_controller_OH),
        .code              (code),
        .busy              (busy),
        .halted            (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: read data appears one cycle after the address.
    always @(posedge clk) begin
        instr <= rom[address];
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [22:0] enc(input logic [2:0] aluop, input logic [2:0] opc,
                                        input logic [2:0] rx, input logic [2:0] ry);
        return {aluop, opc, rx, ry, 11'b0};
    endfunction

    function automatic obs_t snapshot();
        obs_t o;
        o.addr   = address;
        o.ren    = r_en_OH;
        o.tsel   = tri_controller_OH;
        o.code   = code;
        o.busy   = busy;
        o.halted = halted;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        run   = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fillRom(input logic [22:0] w);
        for (int i = 0; i < 64; i++) rom[i] = w;
    endtask

    task automatic checkOutput(input string name, input logic [95:0] actual,
                               input logic [95:0] expected);
        assertions++;
        last_ok = (actual === expected);
        if (!last_ok) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

`ifndef CPU_CTRL_STEP_EN
    vec_t vecs [10];
    obs_t exp_q [$];

    function automatic vec_t mk(input logic [22:0] w0, input logic [22:0] w1,
                                input int cyc, input int n,
                                input logic [19:0] r0, input logic [19:0] t0, input logic [22:0] c0,
                                input logic [19:0] r1, input logic [19:0] t1, input logic [22:0] c1,
                                input logic [19:0] r2, input logic [19:0] t2, input logic [22:0] c2);
        vec_t v;
        v.w0      = w0;
        v.w1      = w1;
        v.cycles  = cyc[7:0];
        v.n_act   = n[7:0];
        v.ren[0]  = r0; v.tsel[0] = t0; v.code[0] = c0;
        v.ren[1]  = r1; v.tsel[1] = t1; v.code[1] = c1;
        v.ren[2]  = r2; v.tsel[2] = t2; v.code[2] = c2;
        return v;
    endfunction

    // Runs one instruction followed by halt; records busy cycles and every
    // cycle that drives a nonzero control, then compares with the vector.
    task automatic applyStimulus(input vec_t v, input int idx);
        int               busy_cnt;
        int               n_act;
        logic [2:0][19:0] ren_seen;
        logic [2:0][19:0] tsel_seen;
        logic [2:0][22:0] code_seen;
        fillRom(HALT_W);
        rom[0] = v.w0;
        rom[1] = v.w1;
        doReset();
        run       = 1'b1;
        busy_cnt  = 0;
        n_act     = 0;
        ren_seen  = '0;
        tsel_seen = '0;
        code_seen = '0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (halted) break;
            if (busy) busy_cnt++;
            if ((r_en_OH != 0) || (tri_controller_OH != 0) || (code != 0)) begin
                if (n_act < 3) begin
                    ren_seen[n_act]  = r_en_OH;
                    tsel_seen[n_act] = tri_controller_OH;
                    code_seen[n_act] = code;
                end
                n_act++;
            end
        end
        checkOutput($sformatf("vec%0d_cycles", idx), 96'(busy_cnt), 96'(v.cycles));
        checkOutput($sformatf("vec%0d_active_cycles", idx), 96'(n_act), 96'(v.n_act));
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("vec%0d_act%0d_code_tri_ren", idx, j),
                        96'({code_seen[j], tsel_seen[j], ren_seen[j]}),
                        96'({v.code[j], v.tsel[j], v.ren[j]}));
        end
        checkOutput($sformatf("vec%0d_halted", idx), 96'(halted), 96'd1);
    endtask

    task automatic pushObs(input int a, input logic [19:0] ren, input logic [19:0] tsel,
                           input logic [22:0] c, input logic b, input logic h);
        obs_t o;
        o.addr   = a[5:0];
        o.ren    = ren;
        o.tsel   = tsel;
        o.code   = c;
        o.busy   = b;
        o.halted = h;
        exp_q.push_back(o);
    endtask

    // Instruction-level interpreter producing the expected per-cycle outputs
    // of the program in rom[] with run held high from address 0.
    task automatic buildTrace(input int ncycles);
        int          pc;
        int          rx;
        int          ry;
        logic [22:0] w;
        logic [22:0] iw;
        exp_q.delete();
        pc = 0;
        while (exp_q.size() < ncycles) begin
            w  = rom[pc];
            rx = int'(w[16:14]);
            ry = int'(w[13:11]);
            pushObs(pc, 0, 0, 0, 1'b1, 1'b0);
            pushObs(pc, 0, 0, 0, 1'b1, 1'b0);
            pc = (pc + 1) % 64;
            case (w[19:17])
                3'd0: pushObs(pc, 20'd1 << rx, 20'd1 << ry, 0, 1'b1, 1'b0);
                3'd1: begin
                    iw = rom[pc];
                    pushObs(pc, 0, 0, 0, 1'b1, 1'b0);
                    pushObs(pc, 0, 0, 0, 1'b1, 1'b0);
                    pushObs(pc, 20'd1 << rx, 20'h200, {7'b0, iw[15:0]}, 1'b1, 1'b0);
                    pc = (pc + 1) % 64;
                end
                3'd2: begin
                    pushObs(pc, 20'h200, 20'd1 << rx, 0, 1'b1, 1'b0);
                    pushObs(pc, 20'h100, 20'd1 << ry, {w[22:20], 20'b0}, 1'b1, 1'b0);
                    pushObs(pc, 20'd1 << rx, 20'h100, 0, 1'b1, 1'b0);
                end
                3'd7: begin
                    while (exp_q.size() < ncycles) pushObs(pc, 0, 0, 0, 1'b0, 1'b1);
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic randomProgram();
        logic [22:0] w;
        logic [2:0]  opc;
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 15))
                0, 1, 2, 3:  opc = 3'd0;
                4, 5, 6:     opc = 3'd1;
                7, 8, 9, 10: opc = 3'd2;
                11:          opc = 3'd3;
                12, 13, 14:  opc = 3'($urandom_range(4, 6));
                default:     opc = 3'd7;
            endcase
            w        = 23'($urandom());
            w[19:17] = opc;
            rom[i]   = w;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step  = 1'b0;
`endif
        fillRom(HALT_W);
        doReset();
        checkOutput("reset_state", 96'(snapshot()), 96'd0);

`ifdef CPU_CTRL_STEP_EN
        begin
            int cnt;
            fillRom(HALT_W);
            rom[0] = enc(3'd0, 3'd0, 3'd1, 3'd2);
            rom[1] = NOP_W;
            rom[2] = enc(3'd1, 3'd2, 3'd0, 3'd1);
            rom[3] = HALT_W;
            doReset();
            run = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                checkOutput($sformatf("step_run_ignored%0d", k), 96'(busy), 96'd0);
            end
            for (int p = 0; p < 4; p++) begin
                step = 1'b1;
                tick();
                step = 1'b0;
                cnt  = busy ? 1 : 0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    if (!busy) break;
                    cnt++;
                end
                case (p)
                    0: checkOutput("step_mv_cycles", 96'(cnt), 96'd3);
                    1: checkOutput("step_nop_cycles", 96'(cnt), 96'd2);
                    2: checkOutput("step_alu_cycles", 96'(cnt), 96'd5);
                    default: checkOutput("step_halt_cycles", 96'(cnt), 96'd2);
                endcase
                checkOutput($sformatf("step%0d_address", p), 96'(address), 96'(p + 1));
                if (p < 3) begin
                    repeat (3) tick();
                    checkOutput($sformatf("step%0d_idle_after", p),
                                96'({busy, halted}), 96'd0);
                end else begin
                    checkOutput("step_halted", 96'(halted), 96'd1);
                end
            end
        end
`else
        vecs[0] = mk(enc(3'd0, 3'd0, 3'd2, 3'd5), HALT_W, 5, 1,
                     20'h004, 20'h020, 23'h0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(enc(3'd0, 3'd1, 3'd1, 3'd0), 23'h00BEEF, 7, 1,
                     20'h002, 20'h200, 23'h00BEEF, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(enc(3'd3, 3'd2, 3'd4, 3'd6), HALT_W, 7, 3,
                     20'h200, 20'h010, 23'h0, 20'h100, 20'h040, 23'h300000,
                     20'h010, 20'h100, 23'h0);
        vecs[3] = mk(enc(3'd5, 3'd2, 3'd3, 3'd3), HALT_W, 7, 3,
                     20'h200, 20'h008, 23'h0, 20'h100, 20'h008, 23'h500000,
                     20'h008, 20'h100, 23'h0);
        vecs[4] = mk(enc(3'd0, 3'd3, 3'd1, 3'd2), HALT_W, 4, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(enc(3'd7, 3'd5, 3'd6, 3'd7), HALT_W, 4, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(enc(3'd6, 3'd0, 3'd7, 3'd0) | 23'h7FF, HALT_W, 5, 1,
                     20'h080, 20'h001, 23'h0, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(enc(3'd7, 3'd1, 3'd7, 3'd7) | 23'h7FF, 23'h7FFFFF, 7, 1,
                     20'h080, 20'h200, 23'h00FFFF, 0, 0, 0, 0, 0, 0);
        vecs[8] = mk(enc(3'd2, 3'd4, 3'd0, 3'd1), HALT_W, 4, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9] = mk(enc(3'd1, 3'd6, 3'd5, 3'd5), HALT_W, 4, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Asynchronous reset in the middle of T2.
        fillRom(HALT_W);
        rom[0] = enc(3'd3, 3'd2, 3'd4, 3'd6);
        doReset();
        run = 1'b1;
        repeat (4) tick();
        checkOutput("t2_before_reset_code", 96'(code), 96'h300000);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", 96'(snapshot()), 96'd0);
        tick();
        checkOutput("reset_held_outputs", 96'(snapshot()), 96'd0);
        rst_n = 1'b1;

        // run dropped during an alu instruction, then resumed.
        fillRom(HALT_W);
        rom[0] = enc(3'd2, 3'd2, 3'd1, 3'd2);
        doReset();
        run = 1'b1;
        repeat (3) tick();
        checkOutput("rundrop_t1_ren", 96'(r_en_OH), 96'h200);
        run = 1'b0;
        tick();
        checkOutput("rundrop_t2_code", 96'(code), 96'h200000);
        tick();
        checkOutput("rundrop_t3_ren_tri", 96'({r_en_OH, tri_controller_OH}), 96'({20'h002, 20'h100}));
        tick();
        checkOutput("rundrop_idle", 96'({busy, halted, address}), 96'({1'b0, 1'b0, 6'd1}));
        repeat (2) tick();
        checkOutput("rundrop_idle_hold", 96'({busy, address}), 96'({1'b0, 6'd1}));
        run = 1'b1;
        tick();
        checkOutput("resume_fetch", 96'({busy, address}), 96'({1'b1, 6'd1}));
        repeat (2) tick();
        checkOutput("resume_halt", 96'({halted, busy, address}), 96'({1'b1, 1'b0, 6'd2}));
        run = 1'b0;
        repeat (3) tick();
        checkOutput("halt_persists", 96'(snapshot()), 96'({6'd2, 20'h0, 20'h0, 23'h0, 1'b0, 1'b1}));

        // mvi at address 63 takes its immediate from address 0.
        begin
            logic [5:0] prev_addr;
            bit         found;
            fillRom(NOP_W);
            rom[0]  = 23'h06ABCD;
            rom[63] = enc(3'd0, 3'd1, 3'd5, 3'd0);
            doReset();
            run       = 1'b1;
            found     = 1'b0;
            prev_addr = '0;
            for (int k = 0; k < 400; k++) begin
                prev_addr = address;
                tick();
                if (tri_controller_OH == 20'h200) begin
                    found = 1'b1;
                    break;
                end
            end
            checkOutput("wrap_load_imm_reached", 96'(found), 96'd1);
            checkOutput("wrap_fetch_imm_address", 96'(prev_addr), 96'd0);
            checkOutput("wrap_load_imm", 96'({address, code, r_en_OH}),
                        96'({6'd0, 23'h00ABCD, 20'h020}));
            run = 1'b0;
            tick();
            checkOutput("wrap_after", 96'({busy, address}), 96'({1'b0, 6'd1}));
        end

        // Random programs against the instruction-level model.
        for (int p = 0; p < 4; p++) begin
            randomProgram();
            buildTrace(150);
            doReset();
            run = 1'b1;
            for (int k = 0; k < 150; k++) begin
                tick();
                checkOutput($sformatf("rand%0d_cycle%0d", p, k), 96'(snapshot()), 96'(exp_q[k]));
                if (!last_ok) break;
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
